// File: rtl/eth_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// eth_pkg : shared eth constants, receive FSM state type and CRC-32 byte step
// Rev 1.0
// ----------------------------------------------------------------------------
package eth_pkg;

    localparam logic [31:0] CRC_POLY    = 32'hEDB8_8320;
    localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;

    localparam logic [1:0] PRE_SYM_RMII = 2'b01;
    localparam logic [1:0] SFD_SYM_RMII = 2'b11;
    localparam logic [3:0] PRE_SYM_MII  = 4'h5;
    localparam logic [3:0] SFD_SYM_MII  = 4'hD;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PRE  = 2'd1,
        DATA = 2'd2,
        DROP = 2'd3
    } rx_state_t;

    // Reflected CRC-32 advanced by one byte, LSB first.
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc ^ {24'h0, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
        end
        return c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/eth_crc32.sv
`default_nettype none
// ----------------------------------------------------------------------------
// eth_crc32 : byte-wide CRC-32 register with init and update strobes
// Rev 1.0
// ----------------------------------------------------------------------------
module eth_crc32
    import eth_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        init,
    input  logic        update,
    input  logic [7:0]  data,
    output logic [31:0] crc
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            crc <= CRC_INIT;
        end else if (init) begin
            crc <= CRC_INIT;
        end else if (update) begin
            crc <= crc32_byte(crc, data);
        end
    end

endmodule
`default_nettype wire

// File: rtl/eth_rx_frame.sv
`default_nettype none
// ----------------------------------------------------------------------------
// eth_rx_frame : RMII/MII receive framer - preamble/SFD strip, byte assembly,
//                CRC/length/PHY-error status. ETH_RX_FCS_STRIP_EN drops FCS.
// Rev 1.0
// ----------------------------------------------------------------------------
module eth_rx_frame
    import eth_pkg::*;
#(
    parameter int DW      = 2,
    parameter int MIN_LEN = 64,
    parameter int MAX_LEN = 1518
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [DW-1:0]                eth_rxd,
    input  logic                         eth_crs_dv,
    input  logic                         eth_rx_err,
    output logic                         rx_vld,
    output logic                         rx_last,
    output logic [7:0]                   rx_data,
    output logic                         rx_err,
    output logic                         rx_crc_ok,
    output logic [$clog2(MAX_LEN+1)-1:0] rx_len
);

    localparam int LW    = $clog2(MAX_LEN + 1);
    localparam int BEATS = 8 / DW;
    localparam logic [DW-1:0] PRE_SYM = (DW == 4) ? DW'(PRE_SYM_MII) : DW'(PRE_SYM_RMII);
    localparam logic [DW-1:0] SFD_SYM = (DW == 4) ? DW'(SFD_SYM_MII) : DW'(SFD_SYM_RMII);

    if (DW != 2 && DW != 4) begin : g_bad_dw
        $error("eth_rx_frame: DW must be 2 or 4");
    end

    logic [DW-1:0] r_rxd;
    logic          r_dv, r_er, r_in_vld, r_armed, r_prev_pre;
    rx_state_t     r_state, w_state_nxt;
    logic [1:0]    r_beat;
    logic [7:0]    r_shift, r_byte, r_pend;
    logic [LW-1:0] r_len;
    logic          r_phy_err, r_byte_vld, r_eof, r_eof_err, r_eof_ovf, r_pend_vld;
    logic [7:0]    w_shift, w_in_byte;
    logic          w_beat_last, w_byte_done, w_ovf, w_sfd, w_in_vld;
    logic [31:0]   w_crc;

    // Carrier already high at the first sample after reset means we joined mid-frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rxd    <= '0;
            r_dv     <= 1'b0;
            r_er     <= 1'b0;
            r_in_vld <= 1'b0;
            r_armed  <= 1'b0;
        end else begin
            r_rxd    <= eth_rxd;
            r_dv     <= eth_crs_dv;
            r_er     <= eth_rx_err;
            r_in_vld <= 1'b1;
            if (r_in_vld && !r_dv) begin
                r_armed <= 1'b1;
            end
        end
    end

    assign w_shift     = {r_rxd, r_shift[7:DW]};
    assign w_beat_last = (r_beat == 2'(BEATS - 1));
    assign w_byte_done = (r_state == DATA) && r_dv && w_beat_last;
    assign w_ovf       = w_byte_done && (r_len == LW'(MAX_LEN));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_sfd       = 1'b0;
        case (r_state)
            IDLE: if (r_dv) w_state_nxt = r_armed ? PRE : DROP;
            PRE: begin
                if (!r_dv) begin
                    w_state_nxt = IDLE;
                end else if (r_rxd == SFD_SYM && r_prev_pre) begin
                    w_state_nxt = DATA;
                    w_sfd       = 1'b1;
                end else if (r_rxd != '0 && r_rxd != PRE_SYM) begin
                    w_state_nxt = DROP;
                end
            end
            DATA: begin
                if (!r_dv) begin
                    w_state_nxt = IDLE;
                end else if (w_ovf) begin
                    w_state_nxt = DROP;
                end
            end
            default: if (!r_dv) w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_prev_pre <= 1'b0;
            r_beat     <= '0;
            r_shift    <= '0;
            r_byte     <= '0;
            r_len      <= '0;
            r_phy_err  <= 1'b0;
            r_byte_vld <= 1'b0;
            r_eof      <= 1'b0;
            r_eof_err  <= 1'b0;
            r_eof_ovf  <= 1'b0;
        end else begin
            r_prev_pre <= (r_rxd == PRE_SYM);
            r_byte_vld <= 1'b0;
            r_eof      <= 1'b0;
            if (w_sfd) begin
                r_beat    <= '0;
                r_len     <= '0;
                r_phy_err <= 1'b0;
            end
            if (r_state == DATA) begin
                if (r_dv) begin
                    r_shift <= w_shift;
                    r_beat  <= w_beat_last ? 2'd0 : r_beat + 2'd1;
                    if (r_er) begin
                        r_phy_err <= 1'b1;
                    end
                    if (w_ovf) begin
                        r_eof     <= 1'b1;
                        r_eof_ovf <= 1'b1;
                        r_eof_err <= 1'b1;
                    end else if (w_byte_done) begin
                        r_byte_vld <= 1'b1;
                        r_byte     <= w_shift;
                        r_len      <= r_len + 1'b1;
                    end
                end else begin
                    r_eof     <= 1'b1;
                    r_eof_ovf <= 1'b0;
                    r_eof_err <= r_phy_err | r_er | (r_beat != 2'd0);
                end
            end
        end
    end

    eth_crc32 u_crc (
        .clk    (clk),
        .reset  (reset),
        .init   (w_sfd),
        .update (w_byte_done && !w_ovf),
        .data   (w_shift),
        .crc    (w_crc)
    );

`ifdef ETH_RX_FCS_STRIP_EN
    // Four bytes in flight: whatever is still in here at end of frame is the FCS.
    logic [7:0] r_dly [4];
    logic [2:0] r_dly_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_dly     <= '{default: '0};
            r_dly_cnt <= '0;
        end else if (r_eof) begin
            r_dly_cnt <= '0;
        end else if (r_byte_vld) begin
            r_dly[0] <= r_byte;
            r_dly[1] <= r_dly[0];
            r_dly[2] <= r_dly[1];
            r_dly[3] <= r_dly[2];
            if (r_dly_cnt != 3'd4) begin
                r_dly_cnt <= r_dly_cnt + 3'd1;
            end
        end
    end

    assign w_in_vld  = r_byte_vld && (r_dly_cnt == 3'd4);
    assign w_in_byte = r_dly[3];
`else
    assign w_in_vld  = r_byte_vld;
    assign w_in_byte = r_byte;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pend     <= '0;
            r_pend_vld <= 1'b0;
            rx_vld     <= 1'b0;
            rx_last    <= 1'b0;
            rx_data    <= '0;
            rx_err     <= 1'b0;
            rx_crc_ok  <= 1'b0;
            rx_len     <= '0;
        end else begin
            rx_vld    <= 1'b0;
            rx_last   <= 1'b0;
            rx_data   <= '0;
            rx_err    <= 1'b0;
            rx_crc_ok <= 1'b0;
            rx_len    <= '0;
            if (r_eof) begin
                rx_vld     <= 1'b1;
                rx_last    <= 1'b1;
                rx_data    <= r_pend_vld ? r_pend : 8'h00;
                rx_err     <= r_eof_err | r_eof_ovf | !r_pend_vld | (r_len < LW'(MIN_LEN));
                rx_crc_ok  <= (w_crc == CRC_RESIDUE);
                rx_len     <= r_eof_ovf ? LW'(MAX_LEN) : r_len;
                r_pend_vld <= 1'b0;
            end else if (w_in_vld) begin
                if (r_pend_vld) begin
                    rx_vld  <= 1'b1;
                    rx_data <= r_pend;
                end
                r_pend     <= w_in_byte;
                r_pend_vld <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire
